// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient sequencer slice.
// Holds the filter geometry, the coefficient code constants and the
// sequencer state type. Coefficient codes: 0 = -1, 1 = 0, 2/3 = +1.
package fir_pkg;

  localparam int NUM_TAPS      = 10;
  localparam int CODE_W        = 2;
  localparam int IDX_W         = 4;
  localparam int VEC_W         = NUM_TAPS * CODE_W;
  // 9 delay registers, the output register and the gain-write edge.
  localparam int WARMUP_CYCLES = NUM_TAPS + 1;
  localparam int WARM_W        = $clog2(WARMUP_CYCLES + 1);

  localparam logic [CODE_W-1:0] COEF_NEG  = 2'd0;
  localparam logic [CODE_W-1:0] COEF_ZERO = 2'd1;
  localparam logic [CODE_W-1:0] COEF_POS  = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WARMUP,
    RUN
  } seq_state_t;

endpackage

// File: rtl/fir_coef_sequencer_if.sv
// Bundle between host/config logic, the coefficient sequencer and the
// FIR coefficient write port.
//   Host side   : load_req, coef_vector -> sequencer; load_ack, busy, done,
//                 out_valid, coef_shadow <- sequencer.
//   Filter side : coef_write_enable, coef_number, coef_value <- sequencer.
// master = host / observer side, slave = the sequencer itself.
interface fir_coef_sequencer_if;

  logic                              load_req;
  logic [fir_pkg::VEC_W-1:0]         coef_vector;
  logic                              load_ack;
  logic                              busy;
  logic                              done;
  logic                              out_valid;
  logic                              coef_write_enable;
  logic [fir_pkg::IDX_W-1:0]         coef_number;
  logic [fir_pkg::CODE_W-1:0]        coef_value;
  logic [fir_pkg::VEC_W-1:0]         coef_shadow;

  modport master (
    output load_req, coef_vector,
    input  load_ack, busy, done, out_valid,
           coef_write_enable, coef_number, coef_value, coef_shadow
  );

  modport slave (
    input  load_req, coef_vector,
    output load_ack, busy, done, out_valid,
           coef_write_enable, coef_number, coef_value, coef_shadow
  );

endinterface

// File: rtl/fir_coef_mux.sv
// Pure tap selector: picks the code of tap idx out of a packed coefficient
// vector (tap i at bits [i*CODE_W +: CODE_W]). Codes pass through unchanged.
//   vec  in  VEC_W   packed coefficient codes
//   idx  in  IDX_W   tap index (only 0..NUM_TAPS-1 are meaningful)
//   code out CODE_W  selected code, 0 for out-of-range indices
module fir_coef_mux
  import fir_pkg::*;
(
  input  logic [VEC_W-1:0]  vec,
  input  logic [IDX_W-1:0]  idx,
  output logic [CODE_W-1:0] code
);

  always_comb begin
    code = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      if (idx == IDX_W'(i)) code = vec[i*CODE_W +: CODE_W];
    end
  end

endmodule

// File: rtl/fir_coef_sequencer.sv
// Programs the FIR coefficient bank through its serial write port.
// A request latches one packed vector, which is streamed tap 0..NUM_TAPS-1,
// one tap per clock. The sequencer then times the filter refill and raises
// out_valid once output_data reflects a full window of new coefficients.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of fir_coef_sequencer_if (host request/status and
//              the filter coefficient write port)
// Every output is a flop or a decode of flopped state.
module fir_coef_sequencer
  import fir_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  fir_coef_sequencer_if.slave  bus
);

  seq_state_t         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WARM_W-1:0]  warm_cnt_q, warm_cnt_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [VEC_W-1:0]   shadow_q, shadow_d;
  logic               ack_q, ack_d;
  logic               accept;
  logic [CODE_W-1:0]  mux_code;

  fir_coef_mux u_mux (
    .vec  (vec_q),
    .idx  (idx_q),
    .code (mux_code)
  );

  // Requests are honoured everywhere except during an active write burst;
  // a request arriving in LOAD is dropped and must be retried.
  assign accept = bus.load_req && (state_q != LOAD);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    warm_cnt_d = warm_cnt_q;
    vec_d      = vec_q;
    shadow_d   = shadow_q;
    ack_d      = 1'b0;

    case (state_q)
      LOAD: begin
        if (idx_q == IDX_W'(NUM_TAPS - 1)) begin
          // Last tap written: commit the set to the readback copy.
          state_d    = WARMUP;
          idx_d      = '0;
          warm_cnt_d = '0;
          shadow_d   = vec_q;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      WARMUP: begin
        if (warm_cnt_q == WARM_W'(WARMUP_CYCLES - 1)) begin
          state_d    = RUN;
          warm_cnt_d = '0;
        end else begin
          warm_cnt_d = warm_cnt_q + WARM_W'(1);
        end
      end
      default: ;
    endcase

    // A new request restarts from tap 0 and abandons any refill in progress.
    if (accept) begin
      state_d    = LOAD;
      idx_d      = '0;
      warm_cnt_d = '0;
      vec_d      = bus.coef_vector;
      ack_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      warm_cnt_q <= '0;
      shadow_q   <= '0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      warm_cnt_q <= warm_cnt_d;
      shadow_q   <= shadow_d;
      ack_q      <= ack_d;
    end
    // Latched vector is pure data; it is only consumed while in LOAD.
    vec_q <= vec_d;
  end

  assign bus.load_ack          = ack_q;
  assign bus.busy              = (state_q == LOAD) || (state_q == WARMUP);
  assign bus.done              = (state_q == WARMUP) && (warm_cnt_q == '0);
  assign bus.out_valid         = (state_q == RUN);
  assign bus.coef_write_enable = (state_q == LOAD);
  assign bus.coef_number       = (state_q == LOAD) ? idx_q : '0;
  assign bus.coef_value        = (state_q == LOAD) ? mux_code : '0;
  assign bus.coef_shadow       = shadow_q;

endmodule

// File: tb/tb_fir_coef_sequencer.sv
// Self-checking bench for fir_coef_sequencer. A timeline model tracks how
// many cycles have passed since the current load started and derives every
// output from that offset; table rows and directed sequences check the
// documented latencies and corner cases on top of it.
module tb_fir_coef_sequencer;
  import fir_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_coef_sequencer_if bus ();

  fir_coef_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Timeline model: m_off = cycles since the first write cycle of the load.
  bit               m_active = 1'b0;
  int               m_off    = 0;
  logic [VEC_W-1:0] m_vec    = '0;
  logic [VEC_W-1:0] m_shadow = '0;

  typedef struct {
    logic [VEC_W-1:0]  vec;
    logic [CODE_W-1:0] t0;
    logic [CODE_W-1:0] t5;
    logic [CODE_W-1:0] t9;
  } row_t;

  row_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [30:0] pack_dut();
    return {bus.load_ack, bus.busy, bus.done, bus.out_valid, bus.coef_write_enable,
            bus.coef_number, bus.coef_value, bus.coef_shadow};
  endfunction

  function automatic logic [30:0] pack_model();
    logic              ack, busy, done, vld, we;
    logic [IDX_W-1:0]  num;
    logic [CODE_W-1:0] val;
    ack = 0; busy = 0; done = 0; vld = 0; we = 0; num = '0; val = '0;
    if (m_active) begin
      ack  = (m_off == 0);
      we   = (m_off < NUM_TAPS);
      done = (m_off == NUM_TAPS);
      busy = (m_off < NUM_TAPS + WARMUP_CYCLES);
      vld  = (m_off >= NUM_TAPS + WARMUP_CYCLES);
      if (we) begin
        num = IDX_W'(m_off);
        val = m_vec[m_off*CODE_W +: CODE_W];
      end
    end
    return {ack, busy, done, vld, we, num, val, m_shadow};
  endfunction

  task automatic model_edge();
    bit loading;
    if (rst) begin
      m_active = 1'b0;
      m_off    = 0;
      m_shadow = '0;
    end else begin
      loading = m_active && (m_off < NUM_TAPS);
      if (bus.load_req && !loading) begin
        m_active = 1'b1;
        m_off    = 0;
        m_vec    = bus.coef_vector;
      end else if (m_active) begin
        if (m_off == NUM_TAPS - 1) m_shadow = m_vec;
        if (m_off < 1000) m_off++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("outputs", 32'(pack_dut()), 32'(pack_model()));
  endtask

  // Issue a request held for 'hold' edges, then observe 25 cycles.
  task automatic run_load(input logic [VEC_W-1:0] v, input int hold,
                          output int ack_cnt, output int ack_first, output int done_first,
                          output int valid_first, output int nwrites, output logic v_r1,
                          output logic [CODE_W-1:0] c0, output logic [CODE_W-1:0] c5,
                          output logic [CODE_W-1:0] c9);
    ack_cnt = 0; ack_first = -1; done_first = -1; valid_first = -1; nwrites = 0;
    v_r1 = 1'b1; c0 = 'x; c5 = 'x; c9 = 'x;
    bus.load_req    = 1'b1;
    bus.coef_vector = v;
    for (int r = 1; r <= 25; r++) begin
      tick();
      if (r == 1) bus.coef_vector = VEC_W'($urandom);
      if (r >= hold) bus.load_req = 1'b0;
      if (r == 1) v_r1 = bus.out_valid;
      if (bus.load_ack) begin
        ack_cnt++;
        if (ack_first < 0) ack_first = r;
      end
      if (bus.done && done_first < 0) done_first = r;
      if (bus.out_valid && valid_first < 0) valid_first = r;
      if (bus.coef_write_enable) begin
        nwrites++;
        if (bus.coef_number == 4'd0) c0 = bus.coef_value;
        if (bus.coef_number == 4'd5) c5 = bus.coef_value;
        if (bus.coef_number == 4'd9) c9 = bus.coef_value;
      end
    end
  endtask

  initial begin
    int ack_cnt, ack_first, done_first, valid_first, nwrites;
    logic v_r1, seen;
    logic [CODE_W-1:0] c0, c5, c9;

    tbl[0] = '{vec: 20'hAAAAA, t0: 2'd2, t5: 2'd2, t9: 2'd2};
    tbl[1] = '{vec: 20'h55555, t0: 2'd1, t5: 2'd1, t9: 2'd1};
    tbl[2] = '{vec: 20'h88888, t0: 2'd0, t5: 2'd2, t9: 2'd2};
    tbl[3] = '{vec: 20'hC0003, t0: 2'd3, t5: 2'd0, t9: 2'd3};

    // Reset for two cycles, then idle.
    rst = 1'b1;
    bus.load_req    = 1'b0;
    bus.coef_vector = '0;
    tick();
    tick();
    check("reset_outputs", 32'(pack_dut()), 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      seen = seen | bus.out_valid | bus.busy | bus.coef_write_enable;
    end
    check("idle_quiet", 32'(seen), 32'd0);

    // Table-driven single-cycle loads; rows after the first load from RUN.
    for (int k = 0; k < 4; k++) begin
      run_load(tbl[k].vec, 1, ack_cnt, ack_first, done_first, valid_first, nwrites, v_r1, c0, c5, c9);
      check("ack_count",   32'(ack_cnt), 32'd1);
      check("ack_cycle",   32'(ack_first), 32'd1);
      check("write_count", 32'(nwrites), 32'd10);
      check("done_cycle",  32'(done_first), 32'd11);
      check("valid_cycle", 32'(valid_first), 32'd22);
      check("valid_r1",    32'(v_r1), 32'd0);
      check("tap0_code",   32'(c0), 32'(tbl[k].t0));
      check("tap5_code",   32'(c5), 32'(tbl[k].t5));
      check("tap9_code",   32'(c9), 32'(tbl[k].t9));
      check("shadow",      32'(bus.coef_shadow), 32'(tbl[k].vec));
    end

    // Request held through the whole burst: one ack, no restart.
    run_load(20'h12345, 10, ack_cnt, ack_first, done_first, valid_first, nwrites, v_r1, c0, c5, c9);
    check("held_ack_count",   32'(ack_cnt), 32'd1);
    check("held_write_count", 32'(nwrites), 32'd10);
    check("held_done_cycle",  32'(done_first), 32'd11);
    check("held_valid_cycle", 32'(valid_first), 32'd22);
    check("held_tap0",        32'(c0), 32'd1);
    check("held_tap9",        32'(c9), 32'd0);
    check("held_shadow",      32'(bus.coef_shadow), 32'h12345);

    // Reset on the 5th write cycle.
    bus.load_req    = 1'b1;
    bus.coef_vector = 20'h3C3C3;
    for (int r = 1; r <= 5; r++) begin
      tick();
      bus.load_req = 1'b0;
    end
    check("mid_load_number", 32'(bus.coef_number), 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_we",     32'(bus.coef_write_enable), 32'd0);
    check("rst_busy",   32'(bus.busy), 32'd0);
    check("rst_shadow", 32'(bus.coef_shadow), 32'd0);
    run_load(20'hAAAAA, 1, ack_cnt, ack_first, done_first, valid_first, nwrites, v_r1, c0, c5, c9);
    check("post_rst_done",   32'(done_first), 32'd11);
    check("post_rst_valid",  32'(valid_first), 32'd22);
    check("post_rst_shadow", 32'(bus.coef_shadow), 32'hAAAAA);

    // Random traffic against the timeline model.
    for (int i = 0; i < 600; i++) begin
      bus.load_req    = ($urandom_range(0, 14) == 0);
      bus.coef_vector = VEC_W'($urandom);
      rst             = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    bus.load_req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_coef_sequencer.md
Name: fir_coef_sequencer

Overview:
Controller that programs the 10-tap, 2-bit-code FIR coefficient bank through its serial write port.
- Accepts one packed coefficient vector per request and streams it tap-by-tap, one tap per clock, over coef_write_enable/coef_number/coef_value.
- Times the filter's pipeline refill after a load and flags when output_data again reflects a full window under the new coefficients.
- Sits between the host/config logic and the FIR datapath; drives all of the filter's coefficient inputs.

Parameters:
- NUM_TAPS, 10, number of coefficients and taps in the filter.
- IDX_W, 4, width of coef_number; must satisfy 2**IDX_W >= NUM_TAPS.
- CODE_W, 2, coefficient code width. Codes: 0 = -1, 1 = 0, 2/3 = +1.
- WARMUP_CYCLES, NUM_TAPS+1, refill cycles after the last write: 9 delay registers, the output register, and the gain-write edge.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- load_req  in  1  request to program a new coefficient set; sampled every cycle.
- coef_vector  in  NUM_TAPS*CODE_W  packed codes; tap i is bits [i*CODE_W +: CODE_W]. Sampled only on the accept cycle.
- load_ack  out  1  one-cycle pulse: request accepted, vector latched.
- busy  out  1  high in LOAD and WARMUP.
- done  out  1  one-cycle pulse in the first WARMUP cycle: all taps written.
- out_valid  out  1  high in RUN only; filter output fully reflects the current coefficients.
- coef_write_enable  out  1  to filter.
- coef_number  out  IDX_W  to filter.
- coef_value  out  CODE_W  to filter.
- coef_shadow  out  NUM_TAPS*CODE_W  copy of the last fully written vector (readback).

Behaviour:
- States: IDLE, LOAD, WARMUP, RUN. All state and outputs are registered or decoded from registered state; no combinational path from input to output.
- Reset values: state = IDLE, idx = 0, warm_cnt = 0, coef_shadow = 0. All control outputs are 0 (coef_write_enable, load_ack, done, busy, out_valid). coef_number = 0, coef_value = 0.
- IDLE: coefficients are undefined, out_valid = 0. If load_req = 1, latch coef_vector, set idx = 0, go to LOAD, and pulse load_ack in the following cycle.
- LOAD: coef_write_enable = 1, coef_number = idx, coef_value = latched[idx*CODE_W +: CODE_W].
  - idx increments each cycle. After the cycle with idx = NUM_TAPS-1, go to WARMUP.
  - LOAD lasts exactly NUM_TAPS cycles (writes taps 0..9 in ascending order).
  - On that final edge, coef_shadow takes the latched vector.
- load_req while in LOAD: ignored. No ack, no queuing; the host must retry.
- WARMUP: coef_write_enable = 0. done pulses in the first cycle only. warm_cnt counts 0..WARMUP_CYCLES-1, then the state goes to RUN.
- RUN: out_valid = 1, busy = 0. Stays until load_req.
- load_req in WARMUP or RUN: accepted as in IDLE.
  - out_valid drops on the next cycle.
  - warm_cnt is cleared.
  - A new LOAD starts from tap 0.
- Latency: request edge to first write = 1 cycle. Request to done = NUM_TAPS+1 cycles. Request to out_valid = NUM_TAPS + WARMUP_CYCLES + 1 = 22 cycles at defaults.
- Reset mid-LOAD: immediate return to IDLE. The filter bank may be partially written. coef_shadow keeps its reset value 0, since reset clears it and the partial set is never committed.
- The write index never exceeds NUM_TAPS-1; indices 10..15 are never driven.
- Width rules: idx is IDX_W bits; warm_cnt is clog2(WARMUP_CYCLES+1) bits. No arithmetic on the coefficient codes; they pass through unchanged.

Decomposition:
- Shared package fir_pkg holds:
  - NUM_TAPS, CODE_W, IDX_W;
  - code constants COEF_NEG = 2'd0, COEF_ZERO = 2'd1, COEF_POS = 2'd2;
  - the state enum seq_state_t {IDLE, LOAD, WARMUP, RUN}.
- One natural sub-module: fir_coef_mux, a pure tap selector from the latched vector and idx to coef_value.
- Optional top wrapper fir_system, instantiating the sequencer and filter, for integration tests.

Test Plan:
1. rst high 2 cycles, then low with no requests → all outputs 0, state IDLE, out_valid stays 0 for 50 cycles.
2. load_req for 1 cycle with coef_vector = 20'hAAAAA (all +1) → load_ack next cycle. coef_write_enable high 10 cycles with coef_number 0..9 and coef_value 2 each. done at cycle 11. out_valid at cycle 22. coef_shadow = 20'hAAAAA.
3. Integrated with the filter, tap codes alternating 0 and 2 (vector 20'h88888), input held at 8'd5 → after out_valid, output_data = 0. Then all +1 → output_data = 50.
4. load_req held continuously during LOAD → exactly one load_ack; the writes are not restarted.
5. A load in RUN with vector 20'h55555 → out_valid low from the next cycle, a fresh 10-write burst, done, and out_valid high again 22 cycles after the request.
6. rst asserted at the 5th write cycle → next cycle IDLE, coef_write_enable = 0, coef_shadow = 0. A following load completes normally.
